// File: rtl/trace_seq_pkg.sv
// Shared state encoding and parameter defaults for the trace cycle sequencer.
package trace_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_FINISH_CYC  = 10;
  localparam int DEF_NUM_CHK     = 4;
  localparam int DEF_CHK_STRIDE  = 2;
  localparam int DEF_ACK_TIMEOUT = 3;
  localparam int DEF_WRAP_MODE   = 0;
  localparam int DEF_SIM_FINISH  = 1;

endpackage

// File: rtl/trace_seq_chk.sv
// One checkpoint channel: fires once per arm at its cycle count, holds the
// request until acked, and flags a timeout when the wait exceeds ACK_TIMEOUT.
module trace_seq_chk
  import trace_seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FIRE_CYC    = DEF_CHK_STRIDE,
  parameter bit ACTIVE      = 1'b1,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cyc,
  input  logic             fire_en,
  input  logic             rearm,
  input  logic             clear,
  input  logic             ack,
  output logic             req,
  output logic             expire
);

  localparam int              TW     = $clog2(ACK_TIMEOUT + 2);
  localparam logic [WIDTH-1:0] FIRE_W = WIDTH'(FIRE_CYC);
  localparam logic [TW-1:0]    LIMIT  = TW'(ACK_TIMEOUT);

  logic          armed_reg;
  logic          req_reg;
  logic [TW-1:0] wait_reg;
  logic          fire;

  // Armed guards against re-firing while cyc is held at FIRE_W with en low.
  assign fire   = ACTIVE && armed_reg && fire_en && (cyc == FIRE_W);
  assign expire = req_reg && !ack && (wait_reg == LIMIT);
  assign req    = req_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_reg <= 1'b1;
      req_reg   <= 1'b0;
      wait_reg  <= '0;
    end else if (clear) begin
      req_reg  <= 1'b0;
      wait_reg <= '0;
    end else begin
      if (fire) begin
        req_reg  <= 1'b1;
        wait_reg <= '0;
      end else if (req_reg) begin
        if (ack) begin
          req_reg  <= 1'b0;
          wait_reg <= '0;
        end else begin
          wait_reg <= wait_reg + 1'b1;
        end
      end
      if (rearm) armed_reg <= 1'b1;
      else if (fire) armed_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/trace_cycle_sequencer.sv
// Cycle counter with checkpoint requests, ack timeouts and a drain phase
// before completion (or continuous wrapping when WRAP_MODE=1).
module trace_cycle_sequencer
  import trace_seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int FINISH_CYC  = DEF_FINISH_CYC,
  parameter int NUM_CHK     = DEF_NUM_CHK,
  parameter int CHK_STRIDE  = DEF_CHK_STRIDE,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int WRAP_MODE   = DEF_WRAP_MODE,
  parameter int SIM_FINISH  = DEF_SIM_FINISH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_CHK-1:0] chk_ack,
  output logic [WIDTH-1:0]   cyc,
  output logic [NUM_CHK-1:0] chk_req,
  output logic [1:0]         state,
  output logic               done,
  output logic               err
);

  localparam logic [WIDTH-1:0] FINISH_W = WIDTH'(FINISH_CYC);

  generate
    if ((NUM_CHK == 0) || (CHK_STRIDE == 0) ||
        ((WIDTH < 63) && (longint'(FINISH_CYC) >= (longint'(1) << WIDTH)))) begin : g_bad_param
      $error("trace_cycle_sequencer: illegal FINISH_CYC/CHK_STRIDE/NUM_CHK");
    end
  endgenerate

  seq_state_t         state_reg, state_next;
  logic [WIDTH-1:0]   cyc_reg, cyc_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;
  logic [NUM_CHK-1:0] expire;
  logic               rearm, clear, fire_en, at_finish;

  assign fire_en   = (state_reg == RUN);
  assign at_finish = (cyc_reg == FINISH_W);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHK; gi++) begin : g_chk
      trace_seq_chk #(
        .WIDTH      (WIDTH),
        .FIRE_CYC   ((gi + 1) * CHK_STRIDE),
        .ACTIVE     (((gi + 1) * CHK_STRIDE) <= FINISH_CYC),
        .ACK_TIMEOUT(ACK_TIMEOUT)
      ) u_chk (
        .clk    (clk),
        .reset  (reset),
        .cyc    (cyc_reg),
        .fire_en(fire_en),
        .rearm  (rearm),
        .clear  (clear),
        .ack    (chk_ack[gi]),
        .req    (chk_req[gi]),
        .expire (expire[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    done_next  = (WRAP_MODE == 0) ? done_reg : 1'b0;
    err_next   = err_reg;
    rearm      = 1'b0;
    clear      = 1'b0;
    // A timeout anywhere aborts the run before any counting or draining.
    if ((state_reg == RUN || state_reg == DRAIN) && (|expire)) begin
      clear      = 1'b1;
      err_next   = 1'b1;
      done_next  = 1'b0;
      state_next = DONE;
    end else begin
      case (state_reg)
        IDLE: if (en) state_next = RUN;
        RUN: begin
          if (at_finish && (WRAP_MODE == 0)) begin
            state_next = DRAIN;
          end else if (en) begin
            if (at_finish) begin
              cyc_next  = '0;
              done_next = 1'b1;
              rearm     = 1'b1;
            end else begin
              cyc_next = cyc_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          if ((chk_req & ~chk_ack) == '0) begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cyc_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign state = state_reg;
  assign cyc   = cyc_reg;
  assign done  = done_reg;
  assign err   = err_reg;

`ifndef SYNTHESIS
  generate
    if (SIM_FINISH != 0) begin : g_sim_finish
      always @(posedge clk) begin
        if (!reset && state_reg == DRAIN && state_next == DONE && !err_next) begin
          $write("*-* All Finished *-*\n");
          $finish;
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_trace_cycle_sequencer.sv
// Bench for trace_cycle_sequencer: vector table, directed corner sequences and
// randomized runs against a rule-level reference model, over three configs.
module tb_trace_cycle_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        en_a = 0, en_b = 0, en_c = 0;
  logic [3:0]  ack_a = 0, ack_c = 0;
  logic [2:0]  ack_b = 0;
  logic [31:0] cyc_a, cyc_b, cyc_c;
  logic [3:0]  req_a, req_c;
  logic [2:0]  req_b;
  logic [1:0]  st_a, st_b, st_c;
  logic        done_a, done_b, done_c, err_a, err_b, err_c;

  trace_cycle_sequencer #(.SIM_FINISH(0)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .chk_ack(ack_a),
    .cyc(cyc_a), .chk_req(req_a), .state(st_a), .done(done_a), .err(err_a));

  trace_cycle_sequencer #(.WRAP_MODE(1), .FINISH_CYC(5), .CHK_STRIDE(2), .NUM_CHK(3),
                          .SIM_FINISH(0)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .chk_ack(ack_b),
    .cyc(cyc_b), .chk_req(req_b), .state(st_b), .done(done_b), .err(err_b));

  trace_cycle_sequencer #(.FINISH_CYC(8), .SIM_FINISH(0)) dut_c (
    .clk(clk), .reset(reset), .en(en_c), .chk_ack(ack_c),
    .cyc(cyc_c), .chk_req(req_c), .state(st_c), .done(done_c), .err(err_c));

  int n_checks = 0;
  int n_err = 0;

  // Observed outputs of the DUT currently under test.
  int          sel = 0;
  logic [31:0] o_cyc;
  logic [3:0]  o_req;
  logic [1:0]  o_st;
  logic        o_done, o_err;
  always_comb begin
    case (sel)
      1: begin o_cyc = cyc_b; o_req = {1'b0, req_b}; o_st = st_b; o_done = done_b; o_err = err_b; end
      2: begin o_cyc = cyc_c; o_req = req_c; o_st = st_c; o_done = done_c; o_err = err_c; end
      default: begin o_cyc = cyc_a; o_req = req_a; o_st = st_a; o_done = done_a; o_err = err_a; end
    endcase
  end

  // Configuration of the selected DUT, used by the reference model.
  int c_fin, c_str, c_nchk, c_to;
  bit c_wrap;

  // Reference model: phase 0..3 = idle/run/drain/done.
  int         m_phase, m_cyc;
  bit         m_done, m_err;
  logic [3:0] m_req, m_fired;
  int         m_age[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_cyc = 0; m_done = 0; m_err = 0; m_req = '0; m_fired = '0;
    for (int k = 0; k < 4; k++) m_age[k] = 0;
  endfunction

  function automatic void model_step(input logic e, input logic [3:0] a);
    bit tmo;
    int fire;
    if (m_phase == 3) return;
    if (c_wrap) m_done = 0;
    if (m_phase == 0) begin
      if (e) m_phase = 1;
      return;
    end
    tmo = 0;
    for (int k = 0; k < c_nchk; k++)
      if (m_req[k] && !a[k] && (m_age[k] + 1 > c_to)) tmo = 1;
    if (tmo) begin
      m_err = 1; m_req = '0; m_phase = 3; m_done = 0;
      for (int k = 0; k < 4; k++) m_age[k] = 0;
      return;
    end
    for (int k = 0; k < c_nchk; k++)
      if (m_req[k]) begin
        if (a[k]) begin m_req[k] = 0; m_age[k] = 0; end
        else m_age[k]++;
      end
    if (m_phase == 2) begin
      if (m_req == 0) begin m_phase = 3; m_done = 1; end
      return;
    end
    for (int k = 0; k < c_nchk; k++) begin
      fire = (k + 1) * c_str;
      if (fire <= c_fin && !m_fired[k] && m_cyc == fire) begin
        m_req[k] = 1; m_age[k] = 0; m_fired[k] = 1;
      end
    end
    if (m_cyc == c_fin && !c_wrap) m_phase = 2;
    else if (e) begin
      if (m_cyc == c_fin) begin m_cyc = 0; m_done = 1; m_fired = '0; end
      else m_cyc++;
    end
  endfunction

  task automatic select_dut(input int i);
    sel = i;
    case (i)
      1: begin c_fin = 5;  c_str = 2; c_nchk = 3; c_to = 3; c_wrap = 1; end
      2: begin c_fin = 8;  c_str = 2; c_nchk = 4; c_to = 3; c_wrap = 0; end
      default: begin c_fin = 10; c_str = 2; c_nchk = 4; c_to = 3; c_wrap = 0; end
    endcase
  endtask

  task automatic drive(input logic e, input logic [3:0] a);
    en_a = 0; ack_a = 0; en_b = 0; ack_b = 0; en_c = 0; ack_c = 0;
    case (sel)
      1: begin en_b = e; ack_b = a[2:0]; end
      2: begin en_c = e; ack_c = a; end
      default: begin en_a = e; ack_a = a; end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cyc"},   64'(o_cyc),  64'(m_cyc));
    check({tag, ".state"}, 64'(o_st),   64'(m_phase));
    check({tag, ".req"},   64'(o_req),  64'(m_req));
    check({tag, ".done"},  64'(o_done), 64'(m_done));
    check({tag, ".err"},   64'(o_err),  64'(m_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 4'h0);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all("reset");
    reset = 1'b0;
  endtask

  task automatic step(input logic e, input logic [3:0] a, input string tag);
    drive(e, a);
    @(posedge clk);
    model_step(e, a);
    @(negedge clk);
    compare_all(tag);
  endtask

  typedef struct {
    bit         en;
    logic [3:0] ack;
    int         cyc;
    int         st;
    logic [3:0] req;
    bit         done;
    bit         err;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, elapsed, fin, cnt, pen, pack;
    logic [3:0] a;

    // Defaults, en high, each ack one cycle after its request.
    tbl[0]  = '{1'b1, 4'h0, 0,  1, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'h0, 1,  1, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'h0, 2,  1, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'h0, 3,  1, 4'h1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'h1, 4,  1, 4'h0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'h0, 5,  1, 4'h2, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'h2, 6,  1, 4'h0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'h0, 7,  1, 4'h4, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'h4, 8,  1, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'h0, 9,  1, 4'h8, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'h8, 10, 1, 4'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'h0, 10, 2, 4'h0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'h0, 10, 3, 4'h0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 4'hF, 10, 3, 4'h0, 1'b1, 1'b0};

    select_dut(0);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].ack);
      @(posedge clk);
      @(negedge clk);
      $display("vec %0d en=%0b ack=%h -> cyc=%0d state=%0d req=%h done=%0b err=%0b",
               i, tbl[i].en, tbl[i].ack, o_cyc, o_st, o_req, o_done, o_err);
      check($sformatf("vec%0d.cyc", i),   64'(o_cyc),  64'(tbl[i].cyc));
      check($sformatf("vec%0d.state", i), 64'(o_st),   64'(tbl[i].st));
      check($sformatf("vec%0d.req", i),   64'(o_req),  64'(tbl[i].req));
      check($sformatf("vec%0d.done", i),  64'(o_done), 64'(tbl[i].done));
      check($sformatf("vec%0d.err", i),   64'(o_err),  64'(tbl[i].err));
    end

    // Channel 1 never acknowledged: timeout ACK_TIMEOUT+1 cycles after it rises.
    select_dut(0);
    do_reset();
    rise = -1; elapsed = -1; fin = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      step(1'b1, o_req & 4'b1101, "tmo");
      if (rise < 0 && o_req[1]) rise = i;
      if (o_st == 2'd3) begin fin = 1; elapsed = i - rise; end
    end
    $display("timeout seq: req1 rise=%0d done after %0d cycles err=%0b", rise, elapsed, o_err);
    check("tmo.reached_done", 64'(fin), 64'd1);
    check("tmo.latency", 64'(elapsed), 64'(c_to + 1));
    check("tmo.err", 64'(o_err), 64'd1);
    check("tmo.done", 64'(o_done), 64'd0);

    // en toggled every cycle: DONE 23 edges after the first enable.
    select_dut(0);
    do_reset();
    fin = 0; cnt = -1;
    for (int i = 0; i < 40 && !fin; i++) begin
      step((i % 2) == 0, o_req, "toggle");
      if (o_st == 2'd3) begin fin = 1; cnt = i + 1; end
    end
    $display("toggle seq: DONE after %0d edges cyc=%0d", cnt, o_cyc);
    check("toggle.edges", 64'(cnt), 64'd23);
    check("toggle.cyc", 64'(o_cyc), 64'd10);

    // Asynchronous reset mid-run.
    select_dut(0);
    do_reset();
    fin = 0;
    for (int i = 0; i < 20 && !fin; i++) begin
      step(1'b1, o_req, "arst_pre");
      if (o_cyc == 32'd5) fin = 1;
    end
    check("arst.reached_cyc5", 64'(fin), 64'd1);
    #2 reset = 1'b1;
    #1;
    $display("async reset: cyc=%0d state=%0d req=%h done=%0b err=%0b", o_cyc, o_st, o_req, o_done, o_err);
    check("arst.cyc", 64'(o_cyc), 64'd0);
    check("arst.state", 64'(o_st), 64'd0);
    check("arst.req", 64'(o_req), 64'd0);
    check("arst.done_err", 64'({o_done, o_err}), 64'd0);
    model_reset();
    drive(1'b0, 4'h0);
    @(negedge clk);
    compare_all("arst_hold");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, o_req, "arst_post");

    // FINISH_CYC=8: checkpoint 3 fires at finish, DRAIN waits for its late ack.
    select_dut(2);
    do_reset();
    rise = -1; fin = 0; cnt = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      a = o_req & 4'b0111;
      if (rise >= 0 && (i - rise) >= 2) a[3] = o_req[3];
      step(1'b1, a, "drain");
      if (rise < 0 && o_req[3]) rise = i;
      if (o_st == 2'd2) begin
        cnt++;
        check("drain.cyc_frozen", 64'(o_cyc), 64'd8);
      end
      if (o_st == 2'd3) fin = 1;
    end
    $display("drain seq: %0d DRAIN cycles, state=%0d done=%0b", cnt, o_st, o_done);
    check("drain.cycles", 64'(cnt), 64'd2);
    check("drain.done", 64'({o_st, o_done}), 64'({2'd3, 1'b1}));

    // Wrap mode: 0..5 then wrap, one done pulse per wrap, channel 2 silent.
    select_dut(1);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 19; i++) begin
      step(1'b1, o_req, "wrap");
      if (o_done) cnt++;
    end
    $display("wrap seq: %0d done pulses in 19 edges", cnt);
    check("wrap.pulses", 64'(cnt), 64'd3);

    // Randomized runs on every configuration.
    for (int r = 0; r < 12; r++) begin
      select_dut(r % 3);
      do_reset();
      pen = $urandom_range(30, 100);
      pack = $urandom_range(20, 80);
      for (int i = 0; i < 70; i++) begin
        for (int k = 0; k < 4; k++) a[k] = ($urandom_range(0, 99) < pack);
        step($urandom_range(0, 99) < pen, a, $sformatf("rnd%0d", r));
      end
      $display("random run %0d dut=%0d p_en=%0d p_ack=%0d end state=%0d cyc=%0d err=%0b",
               r, sel, pen, pack, o_st, o_cyc, o_err);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/trace_cycle_sequencer.md
TRACE_CYCLE_SEQUENCER -- requirements
Module: trace_cycle_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: cycle counter width in bits.
REQ-002 SHALL have parameter FINISH_CYC, default 10: count value at which the run ends or wraps.
REQ-003 SHALL have parameter NUM_CHK, default 4: number of checkpoint channels.
REQ-004 SHALL have parameter CHK_STRIDE, default 2: checkpoint k fires at cyc == (k+1)*CHK_STRIDE.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 3: maximum cycles a checkpoint request may wait for its ack.
REQ-006 SHALL have parameter WRAP_MODE, default 0: 0 = stop at finish, 1 = wrap and continue.
REQ-007 SHALL have parameter SIM_FINISH, default 1: 1 = print "*-* All Finished *-*\n" and call $finish on entering DONE without error.
REQ-008 SHALL have port clk, input, 1: the single clock; all state changes on its posedge.
REQ-009 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-010 SHALL have port en, input, 1: count enable.
REQ-011 SHALL have port chk_ack, input, NUM_CHK: per-channel acknowledge.
REQ-012 SHALL have port cyc, output, WIDTH: current cycle count.
REQ-013 SHALL have port chk_req, output, NUM_CHK: per-channel checkpoint request.
REQ-014 SHALL have port state, output, 2: IDLE=0, RUN=1, DRAIN=2, DONE=3.
REQ-015 SHALL have port done, output, 1: run complete (level in WRAP_MODE=0, one-cycle pulse per wrap in WRAP_MODE=1).
REQ-016 SHALL have port err, output, 1: sticky checkpoint-timeout flag.

Function
REQ-017 SHALL leave IDLE for RUN on the first posedge with en=1; cyc does not increment on that edge.
REQ-018 SHALL, in RUN, increment cyc by 1 on each posedge with en=1 and hold cyc when en=0.
REQ-019 SHALL set chk_req[k] on the edge after cyc becomes (k+1)*CHK_STRIDE, for (k+1)*CHK_STRIDE <= FINISH_CYC; later channels never fire.
REQ-020 SHALL hold chk_req[k] until chk_ack[k] is sampled high and clear it on that edge; an ack with no pending request is ignored.
REQ-021 SHALL count per-channel wait cycles while chk_req[k]=1, independent of en, and set err on the edge where the wait exceeds ACK_TIMEOUT.
REQ-022 SHALL, on err being set, clear all chk_req and enter DONE with done=0; err holds until reset.
REQ-023 SHALL, with WRAP_MODE=0, enter DRAIN on the edge after cyc reaches FINISH_CYC and freeze cyc at that value.
REQ-024 SHALL leave DRAIN for DONE (done=1) on the first edge with no chk_req pending, or earlier through REQ-022.
REQ-025 SHALL, with WRAP_MODE=1, set cyc to 0 instead of FINISH_CYC+1, stay in RUN, pulse done for one cycle, and re-arm all checkpoints.
REQ-026 SHALL still raise a checkpoint whose fire count equals FINISH_CYC; DRAIN then waits for its ack.
REQ-027 SHALL treat DONE as terminal until reset; en and chk_ack are ignored there.
REQ-028 SHALL fail elaboration if FINISH_CYC >= 2**WIDTH, CHK_STRIDE == 0, or NUM_CHK == 0.

Reset
REQ-029 SHALL, while reset=1, drive cyc=0, chk_req=0, state=IDLE, done=0, err=0, and all timeout counters to 0, immediately and regardless of clk.
REQ-030 SHALL abandon any operation in progress when reset is asserted mid-run; the first en after release starts from REQ-017.

Structure
REQ-031 SHALL place the state encoding enum and the parameter defaults in shared package trace_seq_pkg.
REQ-032 SHALL implement one channel's request, ack and timeout in sub-module trace_seq_chk, instantiated NUM_CHK times.

Verification
REQ-033 Defaults, en held high, each ack given 1 cycle after its req: chk_req pulses at cyc 2/4/6/8 on channels 0-3; DONE at cyc=10; done=1, err=0; message printed once.
REQ-034 Defaults, chk_ack[1] never asserted: err=1 and state=DONE exactly ACK_TIMEOUT+1 cycles after chk_req[1] rises; no message.
REQ-035 en toggled 1/0 every cycle: cyc advances on alternate cycles; DONE is reached at cyc=10 about 20 cycles after start.
REQ-036 WRAP_MODE=1, FINISH_CYC=5, CHK_STRIDE=2, NUM_CHK=3: cyc runs 0..5,0..; done pulses once per wrap; channel 2 never fires.
REQ-037 FINISH_CYC=8, ack for channel 3 delayed 2 cycles: state=DRAIN for 2 cycles with cyc=8, then DONE.
REQ-038 reset asserted asynchronously at cyc=5 mid-RUN: all outputs take reset values before the next posedge; the run restarts cleanly.
